// File: rtl/ans_tx_pkg.sv
// Shared TX-path types: sample format, HT-STF symbol geometry and sequencer state encoding.
// Samples are {I[31:16], Q[15:0]}; the sequencer copies them bit-exact.
package ans_tx_pkg;

  localparam int HT_SYM_LEN = 64;
  localparam int HT_CP_LEN  = 16;
  localparam int SAMPLE_W   = 32;
  localparam int COEFF_W    = 128;
  localparam int IDX_W      = 6;
  localparam int CNT_W      = 7;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_KICK     = 3'd1,
    ST_WAIT_GEN = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_DRAIN    = 3'd4
  } seq_state_e;

  // Output position rd_cnt maps to buffer slot (rd_cnt - cp_len) mod 64, so the CP is the symbol tail.
  function automatic logic [IDX_W-1:0] cp_rd_idx(input logic [CNT_W-1:0] rd_cnt,
                                                 input logic [CNT_W-1:0] cp_len);
    return IDX_W'(rd_cnt - cp_len);
  endfunction

endpackage

// File: rtl/ht_stf_sequencer_if.sv
// Generator-side and stream-side signals of the HT-STF sequencer.
// master = sequencer; slave = generator plus downstream sample mux.
interface ht_stf_sequencer_if;
  import ans_tx_pkg::*;

  logic                gen_letsgo;
  logic                gen_givemeoutput;
  logic [COEFF_W-1:0]  gen_obf_coeff;
  sample_t             gen_sample;
  logic                gen_started;

  sample_t             o_tdata;
  logic                o_tvalid;
  logic                o_tready;
  logic                o_tlast;

  modport master (
    output gen_letsgo, gen_givemeoutput, gen_obf_coeff,
    input  gen_sample, gen_started,
    output o_tdata, o_tvalid, o_tlast,
    input  o_tready
  );

  modport slave (
    input  gen_letsgo, gen_givemeoutput, gen_obf_coeff,
    output gen_sample, gen_started,
    input  o_tdata, o_tvalid, o_tlast,
    output o_tready
  );

endinterface

// File: rtl/ht_sample_buf.sv
// 64x32 sample store: registered write, combinational read (distributed RAM).
module ht_sample_buf
  import ans_tx_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  sample_t          wr_dat_i,
  input  logic [IDX_W-1:0] rd_addr_i,
  output sample_t          rd_dat_o
);

  sample_t mem_q [HT_SYM_LEN];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/ht_stf_sequencer.sv
// Kicks the HT-STF generator, captures its 64 samples, then streams CP + symbol (80 samples).
// letsgo 1 cycle after start; first valid 1 cycle after the 64th capture; stalls hold the beat stable.
module ht_stf_sequencer
  import ans_tx_pkg::*;
#(
  parameter int SYM_LEN = HT_SYM_LEN,
  parameter int CP_LEN  = HT_CP_LEN,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [COEFF_W-1:0]  obf_coeff_in,
  ht_stf_sequencer_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int                TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SYM_LEN + CP_LEN - 1);
  localparam logic [CNT_W-1:0]  CP_CNT   = CNT_W'(CP_LEN);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  WR_LAST  = IDX_W'(SYM_LEN - 1);

  seq_state_e          state_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [IDX_W-1:0]    wr_idx_q;
  logic [CNT_W-1:0]    rd_cnt_q;
  logic [COEFF_W-1:0]  coeff_q;
  logic                letsgo_q;
  logic                give_q;
  logic                tvalid_q;
  logic                done_q;
  logic                error_q;

  logic                buf_we;
  logic [IDX_W-1:0]    buf_waddr;
  logic [IDX_W-1:0]    buf_raddr;
  sample_t             buf_rdat;

  // tmo_q counts cycles elapsed since the letsgo cycle, so the fault lands TIMEOUT cycles after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tmo_q    <= '0;
      wr_idx_q <= '0;
      rd_cnt_q <= '0;
      coeff_q  <= '0;
      letsgo_q <= 1'b0;
      give_q   <= 1'b0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      letsgo_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          tmo_q <= '0;
          if (start) begin
            coeff_q  <= obf_coeff_in;
            error_q  <= 1'b0;
            letsgo_q <= 1'b1;
            state_q  <= ST_KICK;
          end
        end
        ST_KICK: begin
          tmo_q   <= TMO_W'(1);
          give_q  <= 1'b1;
          state_q <= ST_WAIT_GEN;
        end
        ST_WAIT_GEN: begin
          if (bus.gen_started) begin
            give_q   <= 1'b0;
            wr_idx_q <= IDX_W'(1);
            state_q  <= ST_CAPTURE;
          end else if (tmo_q >= TMO_LAST) begin
            give_q  <= 1'b0;
            error_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_CAPTURE: begin
          if (!bus.gen_started) begin
            error_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            wr_idx_q <= wr_idx_q + IDX_W'(1);
            if (wr_idx_q == WR_LAST) begin
              rd_cnt_q <= '0;
              tvalid_q <= 1'b1;
              state_q  <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (tvalid_q && bus.o_tready) begin
            if (rd_cnt_q == LAST_CNT) begin
              tvalid_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= ST_IDLE;
            end else begin
              rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Only WAIT_GEN and CAPTURE write; the generator's recycled tail arrives in DRAIN and is dropped.
  assign buf_we    = bus.gen_started && ((state_q == ST_WAIT_GEN) || (state_q == ST_CAPTURE));
  assign buf_waddr = (state_q == ST_WAIT_GEN) ? '0 : wr_idx_q;
  assign buf_raddr = cp_rd_idx(rd_cnt_q, CP_CNT);

  ht_sample_buf u_buf (
    .clk       (clk),
    .wr_en_i   (buf_we),
    .wr_addr_i (buf_waddr),
    .wr_dat_i  (bus.gen_sample),
    .rd_addr_i (buf_raddr),
    .rd_dat_o  (buf_rdat)
  );

  assign bus.gen_letsgo       = letsgo_q;
  assign bus.gen_givemeoutput = give_q;
  assign bus.gen_obf_coeff    = coeff_q;
  assign bus.o_tvalid         = tvalid_q;
  assign bus.o_tdata          = tvalid_q ? buf_rdat : '0;
  assign bus.o_tlast          = tvalid_q && (rd_cnt_q == LAST_CNT);

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign error = error_q;

endmodule
